// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative divider and its execute-stage users.
// Holds the divider FSM state encoding, the default datapath width and the
// M-extension funct3 codes that select signed_op and quotient/remainder result.
`ifndef DIV_DATAWIDTH
`define DIV_DATAWIDTH 32
`endif

package div_unit_pkg;

    localparam int DATAWIDTH_DEFAULT = `DIV_DATAWIDTH;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // funct3 codes of the divide group (opcode OP, funct7 = 0000001).
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // DIV and REM are the signed forms (funct3[0] == 0).
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

    // REM and REMU select the remainder output (funct3[1] == 1).
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

// File: rtl/div_unit_add_suber.sv
// add_suber: combinational adder/subtractor, s = a + b or a - b.
// Ports: a, b operands; sub_flag selects subtraction; s result; co carry out
// (with sub_flag=1, co=1 means no borrow, i.e. a >= b unsigned). Latency 0, no flow control.
module add_suber #(
    parameter int DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 sub_flag,
    output logic [DATAWIDTH-1:0] s,
    output logic                 co
);

    logic [DATAWIDTH-1:0] b_eff;

    assign b_eff   = sub_flag ? ~b : b;
    assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {{DATAWIDTH{1'b0}}, sub_flag};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Latency: done DATAWIDTH+2 cycles after start, 1 cycle for divide by zero; with
// DIV_EARLY_OUT_EN defined, |dividend| < |divisor| finishes in 2 cycles.
// Handshake: start is sampled only in IDLE; busy stalls the pipeline, done pulses one cycle.
// Ports: clk, rst (sync, active high), start, signed_op, dividend, divisor in;
// busy, done, quotient, remainder, div_zero out (all registered).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quotient,
    output logic [DATAWIDTH-1:0] remainder,
    output logic                 div_zero
);

    function automatic logic [DATAWIDTH-1:0] neg2c(input logic [DATAWIDTH-1:0] x);
        return ~x + DATAWIDTH'(1);
    endfunction

    div_state_e           state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [DATAWIDTH-1:0] quo_q;
    logic [DATAWIDTH-1:0] rem_q;
    logic [CNTW-1:0]      cnt_q;
    // dvd_q shifts the dividend out of its MSB while quotient bits shift into
    // its LSB; after DATAWIDTH steps it holds the unsigned quotient.
    logic [DATAWIDTH-1:0] dvd_q;
    logic [DATAWIDTH-1:0] dsr_q;
    logic [DATAWIDTH-1:0] prem_q;
    logic                 q_neg_q;
    logic                 r_neg_q;

    logic [DATAWIDTH-1:0] dvd_mag;
    logic [DATAWIDTH-1:0] dsr_mag;
    logic                 divisor_is_zero;
    logic [DATAWIDTH-1:0] trial;
    logic [DATAWIDTH-1:0] diff;
    logic                 no_borrow;
    logic                 qbit;
    logic [DATAWIDTH-1:0] prem_next;

    assign dvd_mag         = (signed_op && dividend[DATAWIDTH-1]) ? neg2c(dividend) : dividend;
    assign dsr_mag         = (signed_op && divisor[DATAWIDTH-1])  ? neg2c(divisor)  : divisor;
    assign divisor_is_zero = (divisor == '0);

    assign trial = {prem_q[DATAWIDTH-2:0], dvd_q[DATAWIDTH-1]};

    add_suber #(
        .DATAWIDTH(DATAWIDTH)
    ) u_trial_sub (
        .a        (trial),
        .b        (dsr_q),
        .sub_flag (1'b1),
        .s        (diff),
        .co       (no_borrow)
    );

    // The shifted partial remainder is DATAWIDTH+1 bits wide; its top bit
    // (prem_q MSB) is not fed to the subtractor. When it is set the true trial
    // value is >= 2^DATAWIDTH > divisor, so the subtraction always succeeds and
    // the truncated difference is still exact (it is below the divisor).
    assign qbit      = no_borrow | prem_q[DATAWIDTH-1];
    assign prem_next = qbit ? diff : trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            prem_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q   <= dvd_mag;
                        dsr_q   <= dsr_mag;
                        q_neg_q <= signed_op & (dividend[DATAWIDTH-1] ^ divisor[DATAWIDTH-1]);
                        r_neg_q <= signed_op & dividend[DATAWIDTH-1];
                        prem_q  <= '0;
                        cnt_q   <= CNTW'(DATAWIDTH);
                        if (divisor_is_zero) begin
                            // Results are final now; DONE follows directly.
                            quo_q      <= '1;
                            rem_q      <= dividend;
                            div_zero_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DIV_DONE;
                        end else begin
                            busy_q  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                            if (dvd_mag < dsr_mag) begin
                                dvd_q   <= '0;
                                prem_q  <= dvd_mag;
                                state_q <= DIV_FIX;
                            end else begin
                                state_q <= DIV_CALC;
                            end
`else
                            state_q <= DIV_CALC;
`endif
                        end
                    end
                end
                DIV_CALC: begin
                    prem_q <= prem_next;
                    dvd_q  <= {dvd_q[DATAWIDTH-2:0], qbit};
                    cnt_q  <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_q <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    quo_q      <= q_neg_q ? neg2c(dvd_q)  : dvd_q;
                    rem_q      <= r_neg_q ? neg2c(prem_q) : prem_q;
                    div_zero_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= DIV_DONE;
                end
                DIV_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit (DATAWIDTH = 32).
// Latency is counted in clock cycles from the cycle start was accepted.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Stimulus only: launches one division, scrambles the operand inputs after
    // acceptance, and collects what the DUT shows in its done cycle.
    task automatic run_div(input logic sop, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output logic busy1, output logic done_after);
        @(negedge clk);
        signed_op = sop; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ($urandom & 1) != 0;
        lat = -1; q = '0; r = '0; dz = 1'b0; busy1 = 1'b0; done_after = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (done) begin
                lat = k; q = quotient; r = remainder; dz = div_zero;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_quot: got %h want 0", quotient); end
        n_vec++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_rem: got %h want 0", remainder); end
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat; logic [31:0] q, r; logic dz, b1, da;
        run_div(1'b0, 32'd100, 32'd7, lat, q, r, dz, b1, da);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL udiv_lat: got %0d want 34", lat); end
        n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL udiv_quot: got %h want %h", q, 32'd14); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL udiv_rem: got %h want %h", r, 32'd2); end
        n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL udiv_dz: got %b want 0", dz); end
        n_vec++; if (b1 !== 1'b1) begin n_err++; $display("FAIL udiv_busy: got %b want 1", b1); end
        n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL udiv_done_width: got %b want 0", da); end
    endtask

    task automatic test_signed;
        int lat; logic [31:0] q, r; logic dz, b1, da;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, q, r, dz, b1, da);   // -100 / 7
        n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL sdiv_nn_quot: got %h want fffffff2", q); end
        n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sdiv_nn_rem: got %h want fffffffe", r); end
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, q, r, dz, b1, da);   // 100 / -7
        n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL sdiv_pn_quot: got %h want fffffff2", q); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL sdiv_pn_rem: got %h want 00000002", r); end
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, q, r, dz, b1, da);   // -100 / -7
        n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL sdiv_nnn_quot: got %h want 0000000e", q); end
        n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sdiv_nnn_rem: got %h want fffffffe", r); end
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL sdiv_lat: got %0d want 34", lat); end
    endtask

    task automatic test_div_zero;
        int lat; logic [31:0] q, r; logic dz, b1, da;
        run_div(1'b0, 32'h0000_1234, 32'h0, lat, q, r, dz, b1, da);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dz_lat: got %0d want 1", lat); end
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_quot: got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h0000_1234) begin n_err++; $display("FAIL dz_rem: got %h want 00001234", r); end
        n_vec++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", dz); end
        n_vec++; if (b1 !== 1'b0) begin n_err++; $display("FAIL dz_busy: got %b want 0", b1); end
        n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL dz_done_width: got %b want 0", da); end
        // A following normal divide must clear the flag.
        run_div(1'b0, 32'd77, 32'd5, lat, q, r, dz, b1, da);
        n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b want 0", dz); end
        n_vec++; if (q !== 32'd15) begin n_err++; $display("FAIL dz_next_quot: got %h want 0000000f", q); end
    endtask

    task automatic test_boundaries;
        int lat; logic [31:0] q, r; logic dz, b1, da;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz, b1, da);   // MIN / -1
        n_vec++; if (q !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_quot: got %h want 80000000", q); end
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ovf_rem: got %h want 0", r); end
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, q, r, dz, b1, da);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL umax_quot: got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL umax_rem: got %h want 0", r); end
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, lat, q, r, dz, b1, da);   // large unsigned divisor
        n_vec++; if (q !== 32'd1) begin n_err++; $display("FAIL bigdsr_quot: got %h want 00000001", q); end
        n_vec++; if (r !== 32'h7FFF_FFFE) begin n_err++; $display("FAIL bigdsr_rem: got %h want 7ffffffe", r); end
        run_div(1'b0, 32'hFFFF_FFFF, 32'h0001_0000, lat, q, r, dz, b1, da);
        n_vec++; if (q !== 32'h0000_FFFF) begin n_err++; $display("FAIL shift_quot: got %h want 0000ffff", q); end
        n_vec++; if (r !== 32'h0000_FFFF) begin n_err++; $display("FAIL shift_rem: got %h want 0000ffff", r); end
    endtask

    task automatic test_early_out;
        int lat; logic [31:0] q, r; logic dz, b1, da;
        run_div(1'b0, 32'd5, 32'd9, lat, q, r, dz, b1, da);
        n_vec++; if (lat !== EARLY_LAT) begin n_err++; $display("FAIL early_lat: got %0d want %0d", lat, EARLY_LAT); end
        n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL early_quot: got %h want 0", q); end
        n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL early_rem: got %h want 00000005", r); end
        run_div(1'b1, 32'hFFFF_FFFB, 32'd9, lat, q, r, dz, b1, da);   // -5 / 9
        n_vec++; if (lat !== EARLY_LAT) begin n_err++; $display("FAIL early_s_lat: got %0d want %0d", lat, EARLY_LAT); end
        n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL early_s_quot: got %h want 0", q); end
        n_vec++; if (r !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL early_s_rem: got %h want fffffffb", r); end
    endtask

    task automatic test_ignore_start;
        int lat; logic [31:0] q, r;
        lat = -1; q = '0; r = '0;
        @(negedge clk);
        signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 10) begin
                start = 1'b1; dividend = 32'd7; divisor = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k; q = quotient; r = remainder;
                break;
            end
        end
        start = 1'b0;
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL ign_lat: got %0d want 34", lat); end
        n_vec++; if (q !== 32'd333) begin n_err++; $display("FAIL ign_quot: got %h want 0000014d", q); end
        n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL ign_rem: got %h want 00000001", r); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_start_on_done;
        int lat; logic [31:0] q, r; logic seen;
        seen = 1'b0; lat = -1; q = '0; r = '0;
        @(negedge clk);
        signed_op = 1'b0; dividend = 32'd200; divisor = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL sod_first_done: got %b want 1", seen); end
        // Request during the done cycle: must not be taken.
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sod_not_taken: got busy %b want 0", busy); end
        n_vec++; if (quotient !== 32'd22) begin n_err++; $display("FAIL sod_held_quot: got %h want 00000016", quotient); end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin lat = k; q = quotient; r = remainder; break; end
        end
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL sod_lat: got %0d want 34", lat); end
        n_vec++; if (q !== 32'd10 || r !== 32'd0) begin n_err++; $display("FAIL sod_result: got %h/%h want 0000000a/00000000", q, r); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] q, r; logic dz, b1, da, saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 16) begin
                n_vec++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
                    n_err++; $display("FAIL rstmid_flags: got busy %b done %b dz %b want 0 0 0", busy, done, div_zero);
                end
                n_vec++; if (quotient !== 32'h0 || remainder !== 32'h0) begin
                    n_err++; $display("FAIL rstmid_results: got %h/%h want 0/0", quotient, remainder);
                end
            end
            if (k == 15) rst = 1'b1;
            else rst = 1'b0;
            if (done) saw_done = 1'b1;
        end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
        run_div(1'b0, 32'd77, 32'd5, lat, q, r, dz, b1, da);
        n_vec++; if (lat !== 34) begin n_err++; $display("FAIL rstmid_next_lat: got %0d want 34", lat); end
        n_vec++; if (q !== 32'd15 || r !== 32'd2) begin n_err++; $display("FAIL rstmid_next_result: got %h/%h want 0000000f/00000002", q, r); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_boundaries;
        test_early_out;
        test_ignore_start;
        test_start_on_done;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
